// File: rtl/count_seq_checker.sv
// Sequence checker for a free-running up-counter: locks after LOCK_N good increments,
// flags breaks, counts breaks and wraps. Define SEQ_CHK_STICKY_ERR_EN for a sticky err.
module count_seq_checker #(
    parameter int WIDTH  = 4,
    parameter int LOCK_N = 3,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in_data,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] wrap_cnt
);
`ifdef SEQ_CHK_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, SYNC, LOCK} state_t;

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [3:0]       match_cnt;
    logic [WIDTH-1:0] exp_val;
    logic             hit;

    assign exp_val = prev + WIDTH'(1);
    assign hit     = (in_data == exp_val);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= IDLE;
            prev      <= '0;
            match_cnt <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
            wrap_cnt  <= '0;
        end else begin
            // Pulse mode drops err every edge, sampled or not.
            if (!STICKY) err <= 1'b0;
            if (en) begin
                prev <= in_data;
                case (state)
                    IDLE: begin
                        match_cnt <= '0;
                        state     <= SYNC;
                    end
                    SYNC: begin
                        if (hit) begin
                            match_cnt <= match_cnt + 4'd1;
                            if (match_cnt + 4'd1 == 4'(LOCK_N)) begin
                                state  <= LOCK;
                                locked <= 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCK: begin
                        if (hit) begin
                            if (prev == ALL_ONES && wrap_cnt != CNT_MAX)
                                wrap_cnt <= wrap_cnt + CNT_W'(1);
                        end else begin
                            err       <= 1'b1;
                            locked    <= 1'b0;
                            match_cnt <= '0;
                            state     <= SYNC;
                            if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor
// compares both an 8-bit-counter DUT and a 2-bit-counter (saturating) DUT.
module tb_count_seq_checker;
`ifdef SEQ_CHK_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    typedef struct {
        logic       l;
        logic       e;
        logic [7:0] ec;
        logic [7:0] wc;
    } exp_t;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       en = 1'b0;
    logic [3:0] in_data = '0;
    logic       locked8, err8, locked2, err2;
    logic [7:0] err_cnt8, wrap_cnt8;
    logic [1:0] err_cnt2, wrap_cnt2;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   seen_err = 1'b0;
    logic [3:0] pv;

    always #5 clk = ~clk;

    count_seq_checker #(.WIDTH(4), .LOCK_N(3), .CNT_W(8)) dut8 (
        .clk(clk), .n_rst(n_rst), .en(en), .in_data(in_data),
        .locked(locked8), .err(err8), .err_cnt(err_cnt8), .wrap_cnt(wrap_cnt8));

    count_seq_checker #(.WIDTH(4), .LOCK_N(3), .CNT_W(2)) dut2 (
        .clk(clk), .n_rst(n_rst), .en(en), .in_data(in_data),
        .locked(locked2), .err(err2), .err_cnt(err_cnt2), .wrap_cnt(wrap_cnt2));

    function automatic logic [1:0] sat2(input logic [7:0] v);
        return (v > 8'd3) ? 2'd3 : v[1:0];
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Apply one vector; e is the pulse-mode err value expected after this edge.
    task automatic vec(input logic r, input logic n, input logic [3:0] d,
                       input logic l, input logic e, input logic [7:0] ec, input logic [7:0] wc);
        exp_t x;
        @(negedge clk);
        n_rst = r; en = n; in_data = d;
        @(posedge clk);
        if (!r) seen_err = 1'b0;
        else if (e) seen_err = 1'b1;
        x.l = l; x.e = e | (STICKY & seen_err); x.ec = ec; x.wc = wc;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            chk("locked8",   {7'd0, locked8}, {7'd0, x.l});
            chk("err8",      {7'd0, err8},    {7'd0, x.e});
            chk("err_cnt8",  err_cnt8,        x.ec);
            chk("wrap_cnt8", wrap_cnt8,       x.wc);
            chk("locked2",   {7'd0, locked2}, {7'd0, x.l});
            chk("err2",      {7'd0, err2},    {7'd0, x.e});
            chk("err_cnt2",  {6'd0, err_cnt2},  {6'd0, sat2(x.ec)});
            chk("wrap_cnt2", {6'd0, wrap_cnt2}, {6'd0, sat2(x.wc)});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        vec(0, 0, 0, 0, 0, 0, 0);
        vec(0, 1, 7, 0, 0, 0, 0);
        // lock on 0,1,2,3
        vec(1, 1, 0, 0, 0, 0, 0);
        vec(1, 1, 1, 0, 0, 0, 0);
        vec(1, 1, 2, 0, 0, 0, 0);
        vec(1, 1, 3, 1, 0, 0, 0);
        // run to 15 then wrap to 0
        for (int i = 4; i < 16; i++) vec(1, 1, 4'(i), 1, 0, 0, 0);
        vec(1, 1, 0, 1, 0, 0, 1);
        vec(1, 1, 1, 1, 0, 0, 1);
        vec(1, 1, 2, 1, 0, 0, 1);
        vec(1, 1, 3, 1, 0, 0, 1);
        // break: 5 after 3, relock on 8
        vec(1, 1, 5, 0, 1, 1, 1);
        vec(1, 1, 6, 0, 0, 1, 1);
        vec(1, 1, 7, 0, 0, 1, 1);
        vec(1, 1, 8, 1, 0, 1, 1);
        // en=0 while data jumps; nothing moves
        for (int i = 0; i < 5; i++) vec(1, 0, 4'(9 + 2 * i), 1, 0, 1, 1);
        vec(1, 1, 9, 1, 0, 1, 1);
        for (int i = 10; i < 16; i++) vec(1, 1, 4'(i), 1, 0, 1, 1);
        vec(1, 1, 0, 1, 0, 1, 2);
        // reset mid-LOCK, then relock takes 4 samples
        vec(0, 1, 1, 0, 0, 0, 0);
        vec(1, 1, 7, 0, 0, 0, 0);
        vec(1, 1, 8, 0, 0, 0, 0);
        vec(1, 1, 9, 0, 0, 0, 0);
        vec(1, 1, 10, 1, 0, 0, 0);
        // five breaks with relock; values 15->0 inside SYNC must not count as wraps
        pv = 4'd10;
        for (int k = 1; k <= 5; k++) begin
            pv = pv + 4'd5;
            vec(1, 1, pv, 0, 1, 8'(k), 0);
            pv = pv + 4'd1; vec(1, 1, pv, 0, 0, 8'(k), 0);
            pv = pv + 4'd1; vec(1, 1, pv, 0, 0, 8'(k), 0);
            pv = pv + 4'd1; vec(1, 1, pv, 1, 0, 8'(k), 0);
        end
        // reset clears everything including a sticky err
        vec(0, 1, 0, 0, 0, 0, 0);
        vec(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
